// File: rtl/fb_read_scheduler_pkg.sv
// Shared frame-buffer types: bus widths, pixel layout and arbiter grant codes.
package hdmi_fb_pkg;

  localparam int ADDR_W    = 21;
  localparam int DATA_W    = 24;
  localparam int FRAME_PIX = 307200;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_DISP = 2'd1,
    GNT_CAM0 = 2'd2,
    GNT_CAM1 = 2'd3
  } gnt_e;

  // Scan-out address sequence wraps at the last pixel of the frame.
  function automatic logic [ADDR_W-1:0] next_rd_addr(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(FRAME_PIX - 1)) ? '0 : a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/fb_read_scheduler_if.sv
// Display, camera-write and frame-buffer RAM signals of the read scheduler.
interface fb_read_scheduler_if
  import hdmi_fb_pkg::*;
();

  logic              disp_frame_start;
  logic              disp_pop;
  logic [DATA_W-1:0] disp_pixel;
  logic              disp_underflow;

  logic              cam0_valid;
  logic [ADDR_W-1:0] cam0_addr;
  logic [DATA_W-1:0] cam0_data;
  logic              cam0_ready;
  logic              cam1_valid;
  logic [ADDR_W-1:0] cam1_addr;
  logic [DATA_W-1:0] cam1_data;
  logic              cam1_ready;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output disp_frame_start, disp_pop,
    output cam0_valid, cam0_addr, cam0_data, cam1_valid, cam1_addr, cam1_data,
    output mem_rdata,
    input  disp_pixel, disp_underflow, cam0_ready, cam1_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  disp_frame_start, disp_pop,
    input  cam0_valid, cam0_addr, cam0_data, cam1_valid, cam1_addr, cam1_data,
    input  mem_rdata,
    output disp_pixel, disp_underflow, cam0_ready, cam1_ready,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/fb_read_scheduler_pixel_fifo.sv
// Prefetch pixel FIFO: flush, push/pop, registered head output and fill count.
module pixel_fifo
  import hdmi_fb_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_low,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  pixel_t        push_data,
  input  logic          pop,
  output pixel_t        head_q,
  output logic [CW-1:0] count_q,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  pixel_t        store_q [DEPTH];
  pixel_t        head_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_d;
  logic          do_push, do_pop;

  assign empty = (count_q == '0);

  // Pointer/count update; a pop on empty presents a zero pixel.
  always_comb begin
    do_pop  = pop && !empty && !flush;
    do_push = push && !flush && ((count_q != CW'(DEPTH)) || do_pop);
    head_d  = head_q;
    if (pop && !flush) head_d = empty ? '0 : store_q[rd_ptr_q];
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(do_push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(do_pop);
    count_d  = flush ? '0 : count_q + CW'(do_push) - CW'(do_pop);
  end

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk_low) begin
    if (do_push) store_q[wr_ptr_q] <= push_data;
  end

  // Control and output registers.
  always_ff @(posedge clk_low) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/fb_read_scheduler.sv
// Shares the single-port frame buffer between display prefetch and two camera writers.
module fb_read_scheduler
  import hdmi_fb_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LOW_WATER  = 8,
  parameter int MEM_LAT    = 2
) (
  input logic                clk_low,
  input logic                reset,
  fb_read_scheduler_if.slave bus
);

  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int CW1 = CW + 1;
  localparam logic [CW:0] LOW_LVL  = CW1'(LOW_WATER);
  localparam logic [CW:0] FULL_LVL = CW1'(FIFO_DEPTH);

  gnt_e              gnt;
  logic              frame_start, issue_rd, ret_live, fifo_pop, fifo_empty;
  logic [CW-1:0]     fill, fill_eff, infl_eff, inflight_q, inflight_d;
  logic [CW:0]       credit;
  logic              rr_q, rr_d;       // 0: cam0 wins the next tie, 1: cam1
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, rd_base;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  // Stage 0 is the RAM strobe cycle; stage MEM_LAT carries the read data.
  logic [MEM_LAT:0]  vld_q, vld_d, drop_q, drop_d;
  logic              uf_q, uf_d;
  pixel_t            head;

  assign frame_start = bus.disp_frame_start;

  // Arbitration: urgent display read, then camera round-robin, then prefetch fill.
  always_comb begin
    fill_eff = frame_start ? '0 : fill;
    infl_eff = frame_start ? '0 : inflight_q;
    credit   = {1'b0, fill_eff} + {1'b0, infl_eff};
    gnt      = GNT_NONE;
    if (reset)                                     gnt = GNT_NONE;
    else if (credit < LOW_LVL)                     gnt = GNT_DISP;
    else if (bus.cam0_valid && bus.cam1_valid)     gnt = rr_q ? GNT_CAM1 : GNT_CAM0;
    else if (bus.cam0_valid)                       gnt = GNT_CAM0;
    else if (bus.cam1_valid)                       gnt = GNT_CAM1;
    else if (credit < FULL_LVL)                    gnt = GNT_DISP;
  end

  assign bus.cam0_ready = (gnt == GNT_CAM0);
  assign bus.cam1_ready = (gnt == GNT_CAM1);

  // Next-state for RAM command, read address, credits and the return pipeline.
  always_comb begin
    issue_rd  = (gnt == GNT_DISP);
    rd_base   = frame_start ? '0 : rd_addr_q;
    rd_addr_d = issue_rd ? next_rd_addr(rd_base) : rd_base;
    rr_d      = rr_q;
    if (gnt == GNT_CAM0)      rr_d = 1'b1;
    else if (gnt == GNT_CAM1) rr_d = 1'b0;
    mem_en_d    = (gnt != GNT_NONE);
    mem_we_d    = (gnt == GNT_CAM0) || (gnt == GNT_CAM1);
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    case (gnt)
      GNT_DISP: mem_addr_d = rd_base;
      GNT_CAM0: begin mem_addr_d = bus.cam0_addr; mem_wdata_d = bus.cam0_data; end
      GNT_CAM1: begin mem_addr_d = bus.cam1_addr; mem_wdata_d = bus.cam1_data; end
      default:  ;
    endcase
    // Reads already in the pipe at a frame start belong to the old frame.
    vld_d      = {vld_q[MEM_LAT-1:0], issue_rd};
    drop_d     = {drop_q[MEM_LAT-1:0] | {MEM_LAT{frame_start}}, 1'b0};
    ret_live   = vld_q[MEM_LAT] && !drop_q[MEM_LAT];
    inflight_d = (frame_start ? '0 : inflight_q - CW'(ret_live)) + CW'(issue_rd);
    fifo_pop   = bus.disp_pop && !frame_start;
    uf_d       = fifo_pop && fifo_empty;
  end

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk_low   (clk_low),
    .reset     (reset),
    .flush     (frame_start),
    .push      (ret_live),
    .push_data (bus.mem_rdata),
    .pop       (fifo_pop),
    .head_q    (head),
    .count_q   (fill),
    .empty     (fifo_empty)
  );

  assign bus.disp_pixel     = head;
  assign bus.disp_underflow = uf_q;
  assign bus.mem_en         = mem_en_q;
  assign bus.mem_we         = mem_we_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_wdata      = mem_wdata_q;

  // State registers; reset also forgets any reads still in flight.
  always_ff @(posedge clk_low) begin
    if (reset) begin
      rd_addr_q   <= '0;
      inflight_q  <= '0;
      rr_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      vld_q       <= '0;
      drop_q      <= '0;
      uf_q        <= 1'b0;
    end else begin
      rd_addr_q   <= rd_addr_d;
      inflight_q  <= inflight_d;
      rr_q        <= rr_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      vld_q       <= vld_d;
      drop_q      <= drop_d;
      uf_q        <= uf_d;
    end
  end

endmodule
